// File: rtl/alu_share_arb_pkg.sv
// Shared ALU op codes and sequencer states for the two-client ALU share.
// Op codes 1010-1111 are illegal and yield an error response.
package alu_share_arb_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_OP_MAX = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the port not granted last.
// Purely combinational; no backpressure of its own.
module rr_arb2 (
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_last_grant,
    output logic o_grant_vld,
    output logic o_grant_id
);

    assign o_grant_vld = i_vld0 | i_vld1;
    assign o_grant_id  = (i_vld0 & i_vld1) ? ~i_last_grant : i_vld1;

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one single-cycle ALU between two clients: accept at T, ALU at T+1, response from T+2.
// A held response stalls the sequencer, so the other port's request waits with ready low.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_zero,
    output logic            rsp0_err,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_zero,
    output logic            rsp1_err,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;
    logic              r_owner;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_err;
    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_rsp_take;

    rr_arb2 u_rr_arb2 (
        .i_vld0       (req0_valid),
        .i_vld1       (req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant_vld  (w_grant_vld),
        .o_grant_id   (w_grant_id)
    );

    assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC:    w_next_state = RESP;
            RESP: begin
                if (w_rsp_take) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand registers feed the ALU directly and keep their value between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= 4'd0;
            r_a          <= '0;
            r_b          <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_owner      <= w_grant_id;
            r_op         <= w_grant_id ? req1_op : req0_op;
            r_a          <= w_grant_id ? req1_a  : req0_a;
            r_b          <= w_grant_id ? req1_b  : req0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == EXEC) begin
            if (r_op > ALU_OP_MAX) begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_err    <= 1'b1;
            end else begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
                r_err    <= 1'b0;
            end
        end
    end

    // Ready is masked by reset since IDLE is also the reset state.
    assign req0_ready  = rst_n & w_accept & ~w_grant_id;
    assign req1_ready  = rst_n & w_accept &  w_grant_id;

    assign rsp0_valid  = (r_state == RESP) & ~r_owner;
    assign rsp1_valid  = (r_state == RESP) &  r_owner;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;
    assign rsp0_err    = r_err;
    assign rsp1_err    = r_err;

    assign alu_ctrl    = r_op;
    assign alu_a       = r_a;
    assign alu_b       = r_b;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: reference ALU stub, per-cycle transaction model, directed scenarios.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_share_arb #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SRL:  return a >> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // The ALU instance: garbage on illegal codes so the block must ignore it.
    always_comb begin
        alu_result = alu_ref(alu_ctrl, alu_a, alu_b);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 free, 1 computing, 2 holding a response.
    int          m_ph = 0;
    logic        m_last = 1'b1, m_own = 1'b0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic        m_zero = 1'b0, m_err = 1'b0;

    always @(negedge clk) begin
        logic e_rdy0, e_rdy1;
        if (!rst_n) begin
            m_ph = 0; m_last = 1'b1; m_own = 1'b0; m_op = 4'd0;
            m_a = 0; m_b = 0; m_res = 0; m_zero = 1'b0; m_err = 1'b0;
        end
        e_rdy0 = rst_n && m_ph == 0 && req0_valid && (!req1_valid || m_last);
        e_rdy1 = rst_n && m_ph == 0 && req1_valid && (!req0_valid || !m_last);
        chk("req0_ready", req0_ready, e_rdy0);
        chk("req1_ready", req1_ready, e_rdy1);
        chk("rsp0_valid", rsp0_valid, m_ph == 2 && !m_own);
        chk("rsp1_valid", rsp1_valid, m_ph == 2 && m_own);
        chk("rsp0_result", rsp0_result, m_res);
        chk("rsp1_result", rsp1_result, m_res);
        chk("rsp0_zero", rsp0_zero, m_zero);
        chk("rsp1_zero", rsp1_zero, m_zero);
        chk("rsp0_err", rsp0_err, m_err);
        chk("rsp1_err", rsp1_err, m_err);
        chk("alu_ctrl", alu_ctrl, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        if (rst_n) begin
            if (m_ph == 0) begin
                if (e_rdy0 || e_rdy1) begin
                    m_own  = e_rdy1;
                    m_last = e_rdy1;
                    m_op   = e_rdy1 ? req1_op : req0_op;
                    m_a    = e_rdy1 ? req1_a  : req0_a;
                    m_b    = e_rdy1 ? req1_b  : req0_b;
                    m_ph   = 1;
                end
            end else if (m_ph == 1) begin
                if (m_op > 4'd9) begin
                    m_res = 0; m_zero = 1'b1; m_err = 1'b1;
                end else begin
                    m_res = alu_ref(m_op, m_a, m_b); m_zero = (m_res == 0); m_err = 1'b0;
                end
                m_ph = 2;
            end else if (m_own ? rsp1_ready : rsp0_ready) begin
                m_ph = 0;
            end
        end
    end

    task automatic set_req(input int port, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Returns #1 after the accepting edge; t is the accept cycle.
    task automatic wait_accept(input int port, output int t);
        bit seen = 0;
        t = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (port == 0 ? req0_ready : req1_ready) begin
                seen = 1;
                t = cyc;
            end
        end
        chk($sformatf("accept%0d_seen", port), seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input int port, input int t_acc, input logic [31:0] res,
                            input logic zero, input logic err, input string name);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (port == 0 ? rsp0_valid : rsp1_valid) seen = 1;
        end
        chk({name, "_seen"}, seen, 1);
        chk({name, "_latency"}, cyc - t_acc, 2);
        chk({name, "_result"}, port == 0 ? rsp0_result : rsp1_result, res);
        chk({name, "_zero"}, port == 0 ? rsp0_zero : rsp1_zero, zero);
        chk({name, "_err"}, port == 0 ? rsp0_err : rsp1_err, err);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int t, t1, t2;
        rst_n = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 0, 4'd0, 0, 0);
        set_req(1, 0, 4'd0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single port 0 ADD
        set_req(0, 1, ALU_ADD, 32'd5, 32'd7);
        wait_accept(0, t);
        set_req(0, 0, 4'd0, 0, 0);
        wait_rsp(0, t, 32'd12, 1'b0, 1'b0, "add5_7");

        // Contest from reset: port 0, then port 1, then port 0 again
        do_reset();
        set_req(0, 1, ALU_SUB, 32'd9, 32'd9);
        set_req(1, 1, ALU_XOR, 32'd3, 32'd5);
        wait_accept(0, t);
        set_req(0, 0, 4'd0, 0, 0);
        wait_rsp(0, t, 32'd0, 1'b1, 1'b0, "sub9_9");
        wait_accept(1, t);
        set_req(1, 0, 4'd0, 0, 0);
        wait_rsp(1, t, 32'd6, 1'b0, 1'b0, "xor3_5");
        @(posedge clk); #1;
        set_req(0, 1, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1, ALU_ADD, 32'd2, 32'd2);
        wait_accept(0, t);
        set_req(0, 0, 4'd0, 0, 0);
        wait_rsp(0, t, 32'd2, 1'b0, 1'b0, "third_p0");
        wait_accept(1, t);
        set_req(1, 0, 4'd0, 0, 0);
        wait_rsp(1, t, 32'd4, 1'b0, 1'b0, "third_p1");

        // Port 1 SRA under response backpressure, port 0 waiting
        @(posedge clk); #1;
        set_req(1, 1, ALU_SRA, 32'h8000_0000, 32'd4);
        wait_accept(1, t);
        set_req(1, 0, 4'd0, 0, 0);
        rsp1_ready = 1'b0;
        set_req(0, 1, ALU_ADD, 32'd1, 32'd2);
        wait_rsp(1, t, 32'hF800_0000, 1'b0, 1'b0, "sra_hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp1_valid", rsp1_valid, 1'b1);
            chk("hold_rsp1_result", rsp1_result, 32'hF800_0000);
            chk("hold_req0_ready", req0_ready, 1'b0);
        end
        @(posedge clk); #1 rsp1_ready = 1'b1;
        wait_accept(0, t);
        set_req(0, 0, 4'd0, 0, 0);
        wait_rsp(0, t, 32'd3, 1'b0, 1'b0, "after_hold");

        // Illegal op, then SLT -1 < 1
        @(posedge clk); #1;
        set_req(0, 1, 4'b1100, 32'd8, 32'd8);
        wait_accept(0, t);
        set_req(0, 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        wait_rsp(0, t, 32'd0, 1'b1, 1'b1, "illegal");
        wait_accept(0, t);
        set_req(0, 0, 4'd0, 0, 0);
        wait_rsp(0, t, 32'd1, 1'b0, 1'b0, "slt");

        // Reset during port 1 EXEC drops the operation
        @(posedge clk); #1;
        set_req(1, 1, ALU_SLL, 32'd1, 32'd3);
        wait_accept(1, t);
        set_req(1, 0, 4'd0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_alu_ctrl", alu_ctrl, 4'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp1_valid", rsp1_valid, 1'b0);
        end
        @(posedge clk); #1;
        set_req(0, 1, ALU_ADD, 32'd10, 32'd20);
        set_req(1, 1, ALU_SUB, 32'd5, 32'd7);
        wait_accept(0, t);
        set_req(0, 0, 4'd0, 0, 0);
        wait_rsp(0, t, 32'd30, 1'b0, 1'b0, "post_rst_p0");
        wait_accept(1, t);
        set_req(1, 0, 4'd0, 0, 0);
        wait_rsp(1, t, 32'hFFFF_FFFE, 1'b0, 1'b0, "post_rst_p1");

        // Back-to-back port 0 at the minimum issue interval
        @(posedge clk); #1;
        set_req(0, 1, ALU_AND, 32'hF0, 32'h3C);
        wait_accept(0, t1);
        set_req(0, 1, ALU_OR, 32'hF0, 32'h0F);
        wait_rsp(0, t1, 32'h30, 1'b0, 1'b0, "and");
        wait_accept(0, t2);
        set_req(0, 0, 4'd0, 0, 0);
        chk("issue_interval", t2 - t1, 3);
        wait_rsp(0, t2, 32'hFF, 1'b0, 1'b0, "or");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
